// File: rtl/trig_pkg.sv
// Shared types and constants for the trig request arbiter slice.
// Angles are unsigned 4.8 and trig results are signed 2.12.
package trig_pkg;

  localparam int unsigned ANGLE_W = 12;
  localparam int unsigned TRIG_W  = 14;

  localparam logic [ANGLE_W-1:0] PI_Q      = 12'h324;
  localparam logic [ANGLE_W-1:0] HALF_PI_Q = 12'h192;
  localparam logic [ANGLE_W-1:0] TWO_PI_Q  = 12'h648;

  typedef enum logic [1:0] {
    IDLE,
    SIN,
    COS,
    DONE
  } trig_arb_state_t;

endpackage

// File: rtl/cal_sin.sv
// Combinational sine of a reduced 4.8 angle in [0, 2pi), signed 2.12 result.
// Folds to the first quadrant, then uses the Bhaskara rational form
// sin = 16p / (5*pi^2 - 4p), with p = x*(pi - x) in angle units where pi = 0x324.
// Quadrant endpoints come out exact (0 and +/-0x1000).
module cal_sin
  import trig_pkg::*;
(
  input  logic [ANGLE_W-1:0] angle,
  output logic [TRIG_W-1:0]  sin_out
);

  localparam logic [19:0] DEN_BASE = 20'd808020;  // 5*0x324^2 / 4

  logic               neg;
  logic [ANGLE_W-1:0] half;
  logic [ANGLE_W-1:0] x;
  logic [17:0]        prod;
  logic [19:0]        den;
  logic [31:0]        num;
  logic [12:0]        mag;

  // Fold into [0, pi/2], evaluate magnitude, restore sign.
  always_comb begin
    neg     = (angle >= PI_Q);
    half    = neg ? (angle - PI_Q) : angle;
    x       = (half > HALF_PI_Q) ? (PI_Q - half) : half;
    prod    = {6'd0, x} * {6'd0, PI_Q - x};
    den     = DEN_BASE - {2'd0, prod};
    num     = {prod, 14'd0} + {13'd0, den[19:1]};
    mag     = 13'(num / {12'd0, den});
    sin_out = neg ? (14'd0 - {1'b0, mag}) : {1'b0, mag};
  end

endmodule

// File: rtl/trig_angle_reduce.sv
// Combinational reduction of a 13-bit 4.8 angle into [0, 2pi).
// Two conditional subtracts of 2pi are enough for every input up to 0xFFF
// and for a reduced angle plus pi/2.
module trig_angle_reduce
  import trig_pkg::*;
(
  input  logic [ANGLE_W:0]   angle_in,
  output logic [ANGLE_W-1:0] angle_out
);

  logic [ANGLE_W:0] step1;
  logic [ANGLE_W:0] step2;

  // Subtract 2pi at most twice.
  always_comb begin
    step1 = angle_in;
    if (step1 >= {1'b0, TWO_PI_Q}) begin
      step1 = step1 - {1'b0, TWO_PI_Q};
    end
    step2 = step1;
    if (step2 >= {1'b0, TWO_PI_Q}) begin
      step2 = step2 - {1'b0, TWO_PI_Q};
    end
    angle_out = step2[ANGLE_W-1:0];
  end

endmodule

// File: rtl/trig_req_arbiter.sv
// Round-robin arbiter sharing one cal_sin datapath among NREQ requesters.
// Each accepted request returns sin and cos (cos = sin(angle + pi/2)).
// Optional build macro: TRIG_ARB_CACHE_EN adds a one-entry result cache.
module trig_req_arbiter
  import trig_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
)
(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ANGLE_W-1:0] req_angle,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [TRIG_W-1:0]       rsp_sin,
  output logic [TRIG_W-1:0]       rsp_cos,
  output logic                    busy
);

  trig_arb_state_t    state_q;
  trig_arb_state_t    state_d;

  logic [ID_W-1:0]    rr_q;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic               accept;
  logic               cache_hit;
  int unsigned        arb_idx;

  logic [ANGLE_W-1:0] sel_angle;
  logic [ANGLE_W-1:0] req_reduced;
  logic [ANGLE_W-1:0] angle_q;
  logic [ID_W-1:0]    id_q;
  logic [ANGLE_W:0]   cos_sum;
  logic [ANGLE_W-1:0] cos_angle;
  logic [ANGLE_W-1:0] cal_in;
  logic [TRIG_W-1:0]  cal_out;
  logic [TRIG_W-1:0]  sin_q;

  logic [ID_W-1:0]    rsp_id_q;
  logic [TRIG_W-1:0]  rsp_sin_q;
  logic [TRIG_W-1:0]  rsp_cos_q;
  logic [TRIG_W-1:0]  hit_sin;
  logic [TRIG_W-1:0]  hit_cos;

  // First pending requester at or after the rr pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    arb_idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      arb_idx = (32'(rr_q) + off) % NREQ;
      if (!grant_any && req_valid[arb_idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(arb_idx);
      end
    end
  end

  // Accept strobe, angle select and cal_sin input mux.
  always_comb begin
    accept    = (state_q == IDLE) && grant_any && !Reset;
    req_ready = '0;
    req_ready[grant_id] = accept;
    sel_angle = req_angle[grant_id*ANGLE_W +: ANGLE_W];
    cos_sum   = {1'b0, angle_q} + {1'b0, HALF_PI_Q};
    cal_in    = (state_q == COS) ? cos_angle : angle_q;
  end

  trig_angle_reduce u_req_reduce (
    .angle_in  ({1'b0, sel_angle}),
    .angle_out (req_reduced)
  );

  trig_angle_reduce u_cos_reduce (
    .angle_in  (cos_sum),
    .angle_out (cos_angle)
  );

  cal_sin u_cal_sin (
    .angle   (cal_in),
    .sin_out (cal_out)
  );

`ifdef TRIG_ARB_CACHE_EN
  logic               cache_valid_q;
  logic [ANGLE_W-1:0] cache_angle_q;
  logic [TRIG_W-1:0]  cache_sin_q;
  logic [TRIG_W-1:0]  cache_cos_q;

  // Remember the last fully computed angle; written as COS completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cache_valid_q <= 1'b0;
      cache_angle_q <= '0;
      cache_sin_q   <= '0;
      cache_cos_q   <= '0;
    end else if (state_q == COS) begin
      cache_valid_q <= 1'b1;
      cache_angle_q <= angle_q;
      cache_sin_q   <= sin_q;
      cache_cos_q   <= cal_out;
    end
  end

  assign cache_hit = cache_valid_q && (req_reduced == cache_angle_q);
  assign hit_sin   = cache_sin_q;
  assign hit_cos   = cache_cos_q;
`else
  assign cache_hit = 1'b0;
  assign hit_sin   = '0;
  assign hit_cos   = '0;
`endif

  // Next-state logic; a cache hit skips straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = cache_hit ? DONE : SIN;
      SIN:     state_d = COS;
      COS:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, rr pointer, sin capture and response registers.
  // Response registers load on the edge into DONE so they hold until the next DONE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_q      <= '0;
      angle_q   <= '0;
      id_q      <= '0;
      sin_q     <= '0;
      rsp_id_q  <= '0;
      rsp_sin_q <= '0;
      rsp_cos_q <= '0;
    end else begin
      if (accept) begin
        angle_q <= req_reduced;
        id_q    <= grant_id;
        rr_q    <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        if (cache_hit) begin
          rsp_id_q  <= grant_id;
          rsp_sin_q <= hit_sin;
          rsp_cos_q <= hit_cos;
        end
      end
      if (state_q == SIN) begin
        sin_q <= cal_out;
      end
      if (state_q == COS) begin
        rsp_id_q  <= id_q;
        rsp_sin_q <= sin_q;
        rsp_cos_q <= cal_out;
      end
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sin   = rsp_sin_q;
  assign rsp_cos   = rsp_cos_q;

endmodule

// File: tb/tb_trig_req_arbiter.sv
// Self-checking bench for trig_req_arbiter: directed steps followed by
// randomized request traffic against a behavioural arbitration/trig model.
// Honours TRIG_ARB_CACHE_EN the same way as the design.
module tb_trig_req_arbiter;
  import trig_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;
  localparam int          TOL  = 10;
  localparam real         PI_R = 3.14159265358979;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ANGLE_W-1:0] req_angle;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [TRIG_W-1:0]       rsp_sin;
  logic [TRIG_W-1:0]       rsp_cos;
  logic                    busy;

  int n_assert = 0;
  int n_fail   = 0;

  int model_rr;
  bit model_cache_valid;
  int model_cache_angle;

  always #5 Clk = ~Clk;

  trig_req_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sin   (rsp_sin),
    .rsp_cos   (rsp_cos),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    n_assert++;
    assert ((d <= TOL) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, TOL);
    end
  endtask

  // Ideal trig of angle r where 0x324 stands for pi, scaled to 2.12.
  function automatic int ref_trig(input int r, input bit want_cos);
    real th, v;
    th = real'(r) * PI_R / 804.0;
    v  = 4096.0 * (want_cos ? $cos(th) : $sin(th));
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  function automatic int sext14(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int off = 0; off < NREQ; off++) begin
      if (mask[(model_rr + off) % NREQ]) return (model_rr + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_angle(input int i, input int a);
    logic [11:0] a12;
    a12 = a[11:0];
    req_angle[i*ANGLE_W +: ANGLE_W] = a12;
  endtask

  // Called at posedge+1 with requests already driven; grant g expected this cycle.
  // Returns at posedge+1 of the first IDLE cycle after the response.
  task automatic run_op(input int g, input bit churn);
    int r, lat;
    bit hit;
    logic [NREQ-1:0] drop, add;
    r = int'(req_angle[g*ANGLE_W +: ANGLE_W]) % 1608;
    @(negedge Clk);
    check("req_ready_grant", req_ready, 32'(1) << g);
    check("busy_idle", busy, 0);
    check("rsp_valid_idle", rsp_valid, 0);
    hit = 1'b0;
`ifdef TRIG_ARB_CACHE_EN
    hit = model_cache_valid && (model_cache_angle == r);
`endif
    lat = hit ? 1 : 3;
    model_rr = (g + 1) % NREQ;
    if (!hit) begin
      model_cache_valid = 1'b1;
      model_cache_angle = r;
    end
    @(posedge Clk);
    #1;
    req_valid[g] = 1'b0;
    if (churn) begin
      drop = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      add  = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (drop[i]) begin
          req_valid[i] = 1'b0;
        end else if (add[i] && !req_valid[i]) begin
          req_valid[i] = 1'b1;
          set_angle(i, int'($urandom_range(0, 4095)));
        end
      end
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge Clk);
      check("busy_active", busy, 1);
      check("req_ready_quiet", req_ready, 0);
      if (k < lat) begin
        check("rsp_valid_early", rsp_valid, 0);
      end else begin
        check("rsp_valid_done", rsp_valid, 1);
        check("rsp_id", rsp_id, g);
        check_near("rsp_sin", sext14(rsp_sin), ref_trig(r, 1'b0));
        check_near("rsp_cos", sext14(rsp_cos), ref_trig(r, 1'b1));
      end
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    logic [13:0] saved_sin, saved_cos;
    int g;

    // Reset state, with requests pending to confirm no accept during reset.
    Reset     = 1'b1;
    req_valid = '1;
    req_angle = '0;
    model_rr  = 0;
    model_cache_valid = 1'b0;
    model_cache_angle = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_sin", rsp_sin, 0);
    check("reset_rsp_cos", rsp_cos, 0);
    @(posedge Clk);
    #1;
    Reset     = 1'b0;
    req_valid = '0;

    // Angle 0 from requester 0.
    set_angle(0, 'h000);
    req_valid = 4'b0001;
    run_op(0, 1'b0);
    check("a0_sin", rsp_sin, 'h0000);
    check("a0_cos", rsp_cos, 'h1000);
    check("a0_hold_valid", rsp_valid, 0);

    // pi from requester 1.
    set_angle(1, 'h324);
    req_valid = 4'b0010;
    run_op(1, 1'b0);
    check("pi_sin", rsp_sin, 'h0000);
    check("pi_cos", rsp_cos, 'h3000);
    check("pi_id", rsp_id, 1);

    // 2pi + pi/2 from requester 2, must reduce to pi/2.
    set_angle(2, 'h7DA);
    req_valid = 4'b0100;
    run_op(2, 1'b0);
    check("hp_sin", rsp_sin, 'h1000);
    check("hp_cos", rsp_cos, 'h0000);
    check("hp_id", rsp_id, 2);

    // Largest raw angle.
    set_angle(0, 'hFFF);
    req_valid = 4'b0001;
    run_op(0, 1'b0);

    // Reset during COS: abandoned, pointer back to 0.
    set_angle(1, 'h100);
    req_valid = 4'b0010;
    @(negedge Clk);
    check("rst_grant", req_ready, 4'b0010);
    @(posedge Clk);
    #1;
    req_valid = '0;
    @(negedge Clk);
    check("rst_sin_busy", busy, 1);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_cos_valid", rsp_valid, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_rr = 0;
    model_cache_valid = 1'b0;
    check("rst_after_busy", busy, 0);
    check("rst_after_valid", rsp_valid, 0);
    check("rst_after_sin", rsp_sin, 0);

    // All four together: grants 0,1,2,3 at 4-cycle spacing.
    for (int i = 0; i < NREQ; i++) set_angle(i, int'($urandom_range(0, 4095)));
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      g = pick(req_valid);
      run_op(g, 1'b0);
    end

    // Same angle twice from requester 3: second may come from the cache.
    set_angle(3, 'h192);
    req_valid = 4'b1000;
    run_op(3, 1'b0);
    saved_sin = rsp_sin;
    saved_cos = rsp_cos;
    check("c1_sin", rsp_sin, 'h1000);
    check("c1_cos", rsp_cos, 'h0000);
    req_valid = 4'b1000;
    run_op(3, 1'b0);
    check("c2_sin_same", rsp_sin, saved_sin);
    check("c2_cos_same", rsp_cos, saved_cos);
    check("c2_id", rsp_id, 3);

    // Randomized traffic with requests appearing and dropping while busy.
    for (int it = 0; it < 60; it++) begin
      if (req_valid == '0) begin
        req_valid = 4'($urandom_range(1, 15));
        for (int i = 0; i < NREQ; i++) set_angle(i, int'($urandom_range(0, 4095)));
      end
      g = pick(req_valid);
      run_op(g, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
